// File: rtl/fetch_queue_if.sv
// Fetch-to-memory and fetch-to-decode signal bundle for fetch_queue_unit.
// The master side is the fetch unit; the slave side is the memory/decode/EX environment.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              imem_req;
  logic [XLEN-1:0]   imem_addr;
  logic [XLEN-1:0]   imem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_inst;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_pc_plus4;
  logic [CNT_W-1:0]  q_count;

  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_inst, out_pc, out_pc_plus4, q_count
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_inst, out_pc, out_pc_plus4, q_count
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: owns the PC, issues one request per cycle to a 1-cycle
// synchronous imem, and queues returned {pc, inst} pairs for decode.
module fetch_queue_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  redirect_tgt;
  logic             vld_p1;
  logic [XLEN-1:0]  req_pc_p1;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  q_pc   [DEPTH];
  logic [XLEN-1:0]  q_inst [DEPTH];

  logic             head_vld;
  logic             pop;
  logic             push;
  logic             issue;
  logic [CNT_W:0]   occupancy;

  assign redirect_tgt = bus.redirect_pc & ~XLEN'(3);

  // Credit counts queued entries plus the response still in flight, net of this
  // cycle's pop, so a response always finds a free slot.
  always_comb begin
    head_vld  = !rst && (count != '0);
    pop       = head_vld && bus.out_ready;
    push      = vld_p1 && !bus.redirect_valid && !rst;
    occupancy = {1'b0, count} + (CNT_W+1)'(vld_p1) - (CNT_W+1)'(pop);
    issue     = !rst && !bus.redirect_valid && (occupancy < (CNT_W+1)'(DEPTH));
  end

  assign bus.imem_req     = issue;
  assign bus.imem_addr    = fetch_pc;
  assign bus.out_valid    = head_vld;
  assign bus.out_inst     = head_vld ? q_inst[rd_ptr] : '0;
  assign bus.out_pc       = head_vld ? q_pc[rd_ptr] : '0;
  assign bus.out_pc_plus4 = head_vld ? q_pc[rd_ptr] + XLEN'(4) : '0;
  assign bus.q_count      = rst ? '0 : count;

  // p0: PC / request issue and queue bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      vld_p1   <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= redirect_tgt;
      vld_p1   <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      vld_p1 <= issue;
      if (issue) fetch_pc <= fetch_pc + XLEN'(4);
      if (push)  wr_ptr   <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr   <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // p1: response capture into the queue tail
  always_ff @(posedge clk) begin
    if (issue) req_pc_p1 <= fetch_pc;
    if (push) begin
      q_pc[wr_ptr]   <= req_pc_p1;
      q_inst[wr_ptr] <= bus.imem_rdata;
    end
  end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-level reference model.
module tb_fetch_queue_unit;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] SIG      = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  fetch_queue_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Synchronous instruction memory: word = address ^ SIG, garbage when idle.
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= bus.imem_addr ^ SIG;
    else              bus.imem_rdata <= $urandom;
  end

  // Reference model: FIFO of PCs, one optional in-flight request, the next fetch PC.
  logic [31:0] mq[$];
  bit          m_infl = 1'b0;
  logic [31:0] m_ipc  = '0;
  logic [31:0] m_fpc  = RESET_PC;

  always @(posedge clk) begin : model
    bit pop_m, req_m;
    if (rst) begin
      mq.delete(); m_infl = 1'b0; m_fpc = RESET_PC;
    end else if (bus.redirect_valid) begin
      mq.delete(); m_infl = 1'b0; m_fpc = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      pop_m = (mq.size() > 0) && bus.out_ready;
      req_m = (mq.size() + int'(m_infl) - int'(pop_m)) < DEPTH;
      if (pop_m)  void'(mq.pop_front());
      if (m_infl) mq.push_back(m_ipc);
      if (req_m) begin
        m_ipc = m_fpc;
        m_fpc = m_fpc + 32'd4;
      end
      m_infl = req_m;
    end
  end

  always @(negedge clk) begin : compare
    bit e_valid, e_req;
    e_valid = !rst && (mq.size() > 0);
    e_req   = !rst && !bus.redirect_valid &&
              ((mq.size() + int'(m_infl) - int'(e_valid && bus.out_ready)) < DEPTH);
    chk("imem_req", 32'(bus.imem_req), 32'(e_req));
    if (e_req) chk("imem_addr", bus.imem_addr, m_fpc);
    chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
    chk("q_count", 32'(bus.q_count), rst ? 32'd0 : 32'(mq.size()));
    if (e_valid) begin
      chk("out_pc", bus.out_pc, mq[0]);
      chk("out_inst", bus.out_inst, mq[0] ^ SIG);
      chk("out_pc_plus4", bus.out_pc_plus4, mq[0] + 32'd4);
    end
    if (rst) begin
      chk("rst_out_pc", bus.out_pc, 32'd0);
      chk("rst_out_inst", bus.out_inst, 32'd0);
      chk("rst_out_pc_plus4", bus.out_pc_plus4, 32'd0);
    end
  end

  logic [31:0] pops[$];
  bit          log_en = 1'b0;
  always @(negedge clk)
    if (log_en && bus.out_valid && bus.out_ready) pops.push_back(bus.out_pc);

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // One reset cycle; returns at the start of C0.
  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b1;
    repeat (3) tick();
    mid();
    chk("reset_req", 32'(bus.imem_req), 32'd0);
    chk("reset_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_count", 32'(bus.q_count), 32'd0);

    // Latency and full throughput
    do_reset();
    mid();
    chk("t1_c0_req", 32'(bus.imem_req), 32'd1);
    chk("t1_c0_addr", bus.imem_addr, 32'h0);
    tick(); mid();
    chk("t1_c1_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick(); mid();
      chk("t1_valid", 32'(bus.out_valid), 32'd1);
      chk("t1_pc", bus.out_pc, 32'(4 * i));
    end

    // Stall saturates the queue, release drains in order
    do_reset();
    tick(); tick();
    bus.out_ready = 1'b0;
    tick(); tick(); tick();
    mid();
    chk("t2_count_full", 32'(bus.q_count), 32'd4);
    chk("t2_req_off", 32'(bus.imem_req), 32'd0);
    chk("t2_head_pc", bus.out_pc, 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick(); mid();
      chk("t2_head_held", bus.out_pc, 32'h0);
    end
    tick();
    pops.delete();
    log_en = 1'b1;
    bus.out_ready = 1'b1;
    repeat (12) tick();
    log_en = 1'b0;
    chk("t2_npops_ge8", 32'(pops.size() >= 8), 32'd1);
    for (int i = 0; i < 8; i++)
      if (i < pops.size()) chk("t2_pop_pc", pops[i], 32'(4 * i));

    // Redirect with three queued entries
    do_reset();
    tick(); tick();
    bus.out_ready = 1'b0;
    tick(); tick();
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h100;
    mid();
    chk("t3_count3", 32'(bus.q_count), 32'd3);
    chk("t3_r_req", 32'(bus.imem_req), 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    mid();
    chk("t3_r1_valid", 32'(bus.out_valid), 32'd0);
    chk("t3_r1_addr", bus.imem_addr, 32'h100);
    tick(); mid();
    chk("t3_r2_valid", 32'(bus.out_valid), 32'd0);
    tick(); mid();
    chk("t3_r3_valid", 32'(bus.out_valid), 32'd1);
    chk("t3_r3_pc", bus.out_pc, 32'h100);

    // Back-to-back redirect, misaligned target
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h300;
    tick();
    bus.redirect_pc = 32'h203;
    tick();
    bus.redirect_valid = 1'b0;
    mid();
    chk("t4_addr", bus.imem_addr, 32'h200);
    tick(); tick(); mid();
    chk("t4_pc", bus.out_pc, 32'h200);
    chk("t4_pc_plus4", bus.out_pc_plus4, 32'h204);
    chk("t4_inst", bus.out_inst, 32'h200 ^ SIG);

    // PC wrap at the top of the address space
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    mid();
    chk("t5_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    tick(); mid();
    chk("t5_addr_wrap", bus.imem_addr, 32'h0);
    tick(); mid();
    chk("t5_pc_top", bus.out_pc, 32'hFFFF_FFFC);
    chk("t5_plus4_wrap", bus.out_pc_plus4, 32'h0);
    tick(); mid();
    chk("t5_pc_wrap", bus.out_pc, 32'h0);

    // Reset mid-stream with entries queued and a request in flight
    do_reset();
    tick(); tick();
    bus.out_ready = 1'b0;
    tick(); tick();
    mid();
    chk("t6_count_before", 32'(bus.q_count), 32'd3);
    tick();
    rst = 1'b1;
    mid();
    chk("t6_rst_count", 32'(bus.q_count), 32'd0);
    chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_rst_req", 32'(bus.imem_req), 32'd0);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    mid();
    chk("t6_restart_req", 32'(bus.imem_req), 32'd1);
    chk("t6_restart_addr", bus.imem_addr, RESET_PC);
    chk("t6_restart_count", 32'(bus.q_count), 32'd0);

    // Randomized traffic: stalls, redirects (some near the wrap point), resets
    for (int i = 0; i < 3000; i++) begin
      tick();
      bus.out_ready      = ($urandom % 10) < 7;
      bus.redirect_valid = ($urandom % 20) == 0;
      bus.redirect_pc    = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      rst                = ($urandom % 100) == 0;
    end
    tick();
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
